// File: rtl/debouncer_bank.sv
// Multi-channel debouncer: per-channel synchroniser, stability filter with
// registered rise/fall pulses, and an optional long-press detector.
module debouncer_bank #(
    parameter int           N             = 4,
    parameter int           STABLE_CYCLES = 1_000_000,
    parameter int           SYNC_STAGES   = 2,
    parameter int           LONG_CYCLES   = 100_000_000,
    parameter logic [N-1:0] RESET_VALUE   = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] noisy,
    output logic [N-1:0] clean,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press,
    output logic         any_change
);
    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
        end else begin
            sync_q[0] <= noisy;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          clean_q;
        logic          rise_q;
        logic          fall_q;

        // Only an uninterrupted run of disagreement reaching STABLE_CYCLES flips clean.
        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt     <= '0;
                clean_q <= RESET_VALUE[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s[i] == clean_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    clean_q <= s[i];
                    rise_q  <= s[i];
                    fall_q  <= ~s[i];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign clean[i] = clean_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;

        if (LONG_CYCLES > 0) begin : g_long
            localparam int            HW       = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

            logic [HW-1:0] hold;
            logic          lp_q;

            function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] h);
                return (h == HOLD_MAX) ? h : h + HW'(1);
            endfunction

            // Saturating at HOLD_MAX gives exactly one pulse per press.
            always_ff @(posedge clock) begin
                if (!reset || !clean_q) begin
                    hold <= '0;
                    lp_q <= 1'b0;
                end else begin
                    hold <= hold_inc(hold);
                    lp_q <= (hold == HOLD_MAX - HW'(1));
                end
            end

            assign long_press[i] = lp_q;
        end else begin : g_no_long
            assign long_press[i] = 1'b0;
        end
    end

    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: window-based reference model checked every edge,
// plus directed literal checks taken on the falling edge.
module tb_debouncer_bank;
    localparam int           N      = 4;
    localparam int           STABLE = 4;
    localparam int           SYNC   = 2;
    localparam int           LONG   = 10;
    localparam logic [N-1:0] RV     = '0;
    localparam int           MAXE   = 2048;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] noisy;
    logic [N-1:0] clean, rise, fall, long_press;
    logic         any_change;

    int vectors = 0;
    int misc    = 0;

    debouncer_bank #(
        .N(N), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC),
        .LONG_CYCLES(LONG), .RESET_VALUE(RV)
    ) dut (
        .clock(clock), .reset(reset), .noisy(noisy), .clean(clean),
        .rise(rise), .fall(fall), .long_press(long_press), .any_change(any_change)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // History indexed by edge number; index 0 stands for the pre-reset state.
    logic [N-1:0] nz [0:MAXE];
    logic [N-1:0] sv [0:MAXE];
    logic [N-1:0] cl [0:MAXE];
    bit           rs [0:MAXE];

    initial begin
        int t;
        logic [N-1:0] e_rise, e_fall, e_lp;
        logic v;
        bit run, rwin;
        t = 0;
        nz[0] = RV; sv[0] = RV; cl[0] = RV; rs[0] = 1'b1;
        forever begin
            @(posedge clock);
            t++;
            if (t >= MAXE) begin
                $display("FAIL edge_budget: got %0d edges, expected < %0d", t, MAXE);
                $fatal(1);
            end
            nz[t] = noisy;
            rs[t] = !reset;
            // Synchronised level: the noisy sample SYNC-1 edges back, unless reset intervened.
            rwin = 1'b0;
            for (int j = t - SYNC + 1; j <= t; j++) if (j >= 0 && rs[j]) rwin = 1'b1;
            sv[t] = (rwin || t - SYNC + 1 < 0) ? RV : nz[t - SYNC + 1];
            e_lp = '0;
            for (int c = 0; c < N; c++) begin
                if (rs[t]) begin
                    cl[t][c] = RV[c];
                end else begin
                    v = ~cl[t-1][c];
                    run = (t >= STABLE);
                    for (int j = t - STABLE; j < t; j++) if (j >= 0 && sv[j][c] !== v) run = 1'b0;
                    cl[t][c] = run ? v : cl[t-1][c];
                end
                run = !rs[t] && (t - LONG - 1 >= 0);
                if (run && cl[t-LONG-1][c]) run = 1'b0;
                for (int j = t - LONG; j < t; j++) if (j >= 0 && !cl[j][c]) run = 1'b0;
                e_lp[c] = run;
            end
            e_rise = cl[t] & ~cl[t-1];
            e_fall = rs[t] ? '0 : (~cl[t] & cl[t-1]);
            #1;
            chk($sformatf("clean@%0d", t), clean, cl[t]);
            chk($sformatf("rise@%0d", t), rise, e_rise);
            chk($sformatf("fall@%0d", t), fall, e_fall);
            chk($sformatf("long_press@%0d", t), long_press, e_lp);
            chk($sformatf("any_change@%0d", t), N'(any_change), N'(|(e_rise | e_fall)));
        end
    end

    task automatic wn(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        noisy = '0;
        wn(3);
        reset = 1'b1;

        // Idle after reset
        wn(20);
        chk("idle_clean", clean, 4'b0000);
        chk("idle_pulses", rise | fall | long_press, 4'b0000);

        // Clean step on channel 0
        noisy[0] = 1'b1;
        wn(5);
        chk("step_early", clean, 4'b0000);
        wn(1);
        chk("step_clean", clean, 4'b0001);
        chk("step_rise", rise, 4'b0001);
        chk("step_any", N'(any_change), 4'b0001);
        wn(1);
        chk("step_rise_gone", rise, 4'b0000);

        // Bounce on channel 1
        noisy[1] = 1'b1; wn(3);
        noisy[1] = 1'b0; wn(1);
        noisy[1] = 1'b1;
        wn(5);
        chk("bounce_early", clean[1] | rise[1], 1'b0);
        wn(1);
        chk("bounce_rise", rise, 4'b0010);
        chk("bounce_clean", clean[1], 1'b1);

        // Long press on channel 2, then re-arm
        noisy[2] = 1'b1;
        wn(6);
        chk("lp_rise", rise, 4'b0100);
        wn(9);
        chk("lp_before", long_press[2], 1'b0);
        wn(1);
        chk("lp_fire", long_press[2], 1'b1);
        wn(1);
        chk("lp_once", long_press[2], 1'b0);
        wn(20);
        noisy[2] = 1'b0;
        wn(6);
        chk("lp_release_fall", fall[2], 1'b1);
        wn(2);
        noisy[2] = 1'b1;
        wn(6);
        chk("lp_repress_rise", rise[2], 1'b1);
        wn(10);
        chk("lp_second", long_press[2], 1'b1);

        // All channels together
        noisy = 4'b0000;
        wn(20);
        noisy = 4'b1111;
        wn(6);
        chk("all_rise", rise, 4'b1111);
        chk("all_clean_hi", clean, 4'b1111);
        wn(14);
        noisy = 4'b0000;
        wn(6);
        chk("all_fall", fall, 4'b1111);
        chk("all_clean_lo", clean, 4'b0000);

        // Reset mid-count on channel 3
        wn(10);
        noisy[3] = 1'b1;
        wn(2);
        reset = 1'b0;
        wn(1);
        chk("rst_clean", clean, 4'b0000);
        chk("rst_pulses", rise | fall | long_press, 4'b0000);
        wn(2);
        reset = 1'b1;
        wn(5);
        chk("rst_exit_quiet", clean | rise | fall, 4'b0000);
        wn(1);
        chk("rst_exit_rise", rise, 4'b1000);
        wn(1);
        chk("rst_exit_rise_gone", rise, 4'b0000);
        wn(15);

        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Parametrised multi-channel debouncer for the alarm's pushbuttons, door/hood switches and key inputs, replacing the single-channel 10 ms debouncer. Each channel synchronises its raw asynchronous input, filters it with a per-channel stability counter, and produces a clean level plus single-cycle rise/fall pulses. An optional long-press detector flags inputs held high for a programmable time. The block sits between the board I/O pins and the alarm FSM.

## Interface
- `N`, 4: number of independent channels; must be ≥ 1.
- `STABLE_CYCLES`, 1_000_000: consecutive cycles of disagreement needed before `clean` changes; 10 ms at 100 MHz; must be ≥ 1.
- `SYNC_STAGES`, 2: synchroniser flops per channel; must be ≥ 2.
- `LONG_CYCLES`, 100_000_000: cycles `clean` must stay high before `long_press` fires; 0 disables the detector.
- `RESET_VALUE`, 0: N-bit reset level for the synchroniser flops and `clean`.

- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `noisy`  in  N  raw asynchronous inputs.
- `clean`  out  N  debounced levels.
- `rise`  out  N  one-cycle pulse when `clean[i]` goes 0→1.
- `fall`  out  N  one-cycle pulse when `clean[i]` goes 1→0.
- `long_press`  out  N  one-cycle pulse when `clean[i]` has been high `LONG_CYCLES` cycles.
- `any_change`  out  1  OR-reduction of `rise | fall`; combinational from registered pulses.

## Operation
- Channels are fully independent. There is no cross-channel interaction except `any_change`.
- Synchroniser: a `SYNC_STAGES`-deep shift register per channel. `s[i]` is the last stage.
- Stability counter `cnt[i]` has width `$clog2(STABLE_CYCLES+1)`. Each edge:
  - if `s[i] == clean[i]`: `cnt[i] <= 0`;
  - else if `cnt[i] == STABLE_CYCLES-1`: `clean[i] <= s[i]`, `cnt[i] <= 0`, and pulse `rise[i]` or `fall[i]` per the new level;
  - else `cnt[i] <= cnt[i]+1`.
- Any bounce back to the current `clean` level restarts the count from 0. Only an uninterrupted run qualifies.
- `rise`/`fall` are registered. They are high for exactly the one cycle in which the new `clean` value first appears, and are otherwise 0.
- Hold counter `hold[i]` has width `$clog2(LONG_CYCLES+1)` and is present only when `LONG_CYCLES > 0`:
  - cleared while `clean[i] == 0`;
  - increments each edge while `clean[i] == 1`, saturating at `LONG_CYCLES`;
  - `long_press[i]` pulses for one cycle on the edge where `hold[i]` becomes `LONG_CYCLES`;
  - result: at most one pulse per press; releasing and re-pressing re-arms it.
- `LONG_CYCLES == 0`: `long_press` is tied to 0 and the hold counters are not generated.
- All counter arithmetic is unsigned. The counters never wrap.

## Timing
- Reset (`reset == 0` at an edge):
  - synchroniser flops and `clean` ← `RESET_VALUE`;
  - `cnt`, `hold` ← 0;
  - `rise`, `fall`, `long_press` ← 0;
  - `any_change` = 0.
- Reset takes priority over every other action. Asserting it mid-count discards the count, and no pulse is emitted on reset entry or exit.
- Latency: number as edge 1 the first edge that samples a new `noisy` level. If the level stays steady, `clean`/`rise`/`fall` update on edge `SYNC_STAGES+STABLE_CYCLES`.
- `long_press` fires `LONG_CYCLES` edges after the edge on which `clean` rose.
- If `rise` and `long_press` would coincide on one channel (only possible when `LONG_CYCLES == 0`, which is disabled), the case cannot arise.
- Simultaneous events on different channels are handled independently in the same cycle.
- A `noisy` glitch shorter than `STABLE_CYCLES` cycles after synchronisation never reaches `clean`.

## Test plan
Bench parameters: N=4, STABLE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10, RESET_VALUE=0.

1. Reset release with all `noisy=0`; hold for 20 cycles → all outputs 0 throughout.
2. Step `noisy[0]` 0→1 and hold → `clean[0]` and `rise[0]` go high on edge 6; `rise[0]` is high for 1 cycle; `any_change` equals `rise[0]`.
3. Bounce `noisy[1]`: 1 for 3 cycles, 0 for 1, then 1 steady → `clean[1]` rises 6 edges after the final 0→1. No pulse appears during the bounce.
4. Hold `noisy[2]` high → `long_press[2]` pulses once, 10 edges after `rise[2]`, and never again while held. Release then re-press → a second pulse.
5. Drive `noisy=4'b1111` together, then `4'b0000` 20 cycles later → all four `rise` bits are asserted on the same edge, then all four `fall` bits on the same edge.
6. Hold `noisy[3]` high and assert `reset` low at edge 3 of its count, then release → `clean[3]` is 0 during reset. `rise[3]` fires 6 edges after release, with no spurious pulses.
